// File: rtl/pc_sequencer.sv
// Instruction-address sequencer: registered PC with stall, absolute jump, signed relative
// branch and call/return through a small return-address stack (RAS). All state updates
// happen on the falling clock edge to line up with the rest of the datapath.
module pc_sequencer #(
  parameter int unsigned          PC_WIDTH     = 8,
  parameter int unsigned          OFFSET_WIDTH = 8,
  parameter int unsigned          STACK_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    STALL,
  input  logic                    JUMP,
  input  logic [PC_WIDTH-1:0]     JUMP_ADDR,
  input  logic                    BRANCH,
  input  logic [OFFSET_WIDTH-1:0] BRANCH_OFFSET,
  input  logic                    CALL,
  input  logic                    RET,
  output logic [PC_WIDTH-1:0]     PC,
  output logic                    STACK_EMPTY,
  output logic                    STACK_FULL,
  output logic                    STACK_ERR
);

  // Count must be able to represent 0..STACK_DEPTH inclusive.
  localparam int unsigned     CntW   = $clog2(STACK_DEPTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STACK_DEPTH);

  // Elaboration-time guard on parameter ranges.
  if (OFFSET_WIDTH < 1 || OFFSET_WIDTH > PC_WIDTH || STACK_DEPTH < 1) begin : gen_bad_params
    $error("pc_sequencer: need 1 <= OFFSET_WIDTH <= PC_WIDTH and STACK_DEPTH >= 1");
  end

  // Winning request for this edge, after priority resolution.
  typedef enum logic [2:0] {
    OpHold,
    OpRet,
    OpCall,
    OpJump,
    OpBranch,
    OpInc
  } op_e;

  op_e                           op;
  logic [PC_WIDTH-1:0]           pc_q, pc_d;
  logic [PC_WIDTH-1:0]           pc_inc;
  logic [PC_WIDTH-1:0]           pc_br;
  logic [PC_WIDTH-1:0]           ras_top;
  logic [PC_WIDTH-1:0]           ras_q [STACK_DEPTH];
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic                          err_q, err_d;
  logic                          push;
  logic                          ras_empty, ras_full;
  logic signed [OFFSET_WIDTH-1:0] off_s;
  logic signed [PC_WIDTH-1:0]    off_ext;

  // Wrapping arithmetic falls out of the fixed PC_WIDTH result.
  assign pc_inc  = pc_q + PC_WIDTH'(1);
  assign off_s   = BRANCH_OFFSET;
  assign off_ext = PC_WIDTH'(off_s);
  assign pc_br   = pc_q + $unsigned(off_ext);

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CntMax);

  // Top-of-stack read: entry [count-1]; value is unused when the stack is empty.
  always_comb begin
    ras_top = '0;
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      if (cnt_q == CntW'(i + 1)) begin
        ras_top = ras_q[i];
      end
    end
  end

  // Resolve simultaneous requests: STALL > RET > CALL > JUMP > BRANCH > increment.
  always_comb begin
    op = OpInc;
    if (STALL) begin
      op = OpHold;
    end else if (RET) begin
      op = OpRet;
    end else if (CALL) begin
      op = OpCall;
    end else if (JUMP) begin
      op = OpJump;
    end else if (BRANCH) begin
      op = OpBranch;
    end
  end

  // Next PC, stack count and sticky error for the selected operation.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    err_d = err_q;
    push  = 1'b0;
    unique case (op)
      OpHold: begin
        pc_d = pc_q;
      end
      OpRet: begin
        if (!ras_empty) begin
          pc_d  = ras_top;
          cnt_d = cnt_q - CntW'(1);
        end else begin
          // Underflow: fall through to the next instruction and flag it.
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end
      OpCall: begin
        if (!ras_full) begin
          push  = 1'b1;
          pc_d  = JUMP_ADDR;
          cnt_d = cnt_q + CntW'(1);
        end else begin
          // Overflow: neither push nor jump.
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end
      OpJump: begin
        pc_d = JUMP_ADDR;
      end
      OpBranch: begin
        pc_d = pc_br;
      end
      default: begin
        pc_d = pc_inc;
      end
    endcase
  end

  // PC, stack count and error flag; reset overrides everything.
  always_ff @(negedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Stack storage needs no reset: entries above the count are never read.
  always_ff @(negedge CLOCK) begin
    if (push) begin
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        if (cnt_q == CntW'(i)) begin
          ras_q[i] <= pc_inc;
        end
      end
    end
  end

  assign PC          = pc_q;
  assign STACK_EMPTY = ras_empty;
  assign STACK_FULL  = ras_full;
  assign STACK_ERR   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written reset/underflow sequences,
// randomized run against a queue-based model, and a 12-bit / depth-8 instance.
module tb_pc_sequencer;

  logic CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Instance A: default parameters.
  logic       a_rst, a_stall, a_jump, a_branch, a_call, a_ret;
  logic [7:0] a_jaddr, a_off, a_pc;
  logic       a_empty, a_full, a_err;

  // Instance B: PC_WIDTH=12, STACK_DEPTH=8.
  logic        b_rst, b_stall, b_jump, b_branch, b_call, b_ret;
  logic [11:0] b_jaddr, b_pc;
  logic [7:0]  b_off;
  logic        b_empty, b_full, b_err;

  pc_sequencer dut_a (
    .CLOCK(CLOCK), .RESET(a_rst), .STALL(a_stall), .JUMP(a_jump), .JUMP_ADDR(a_jaddr),
    .BRANCH(a_branch), .BRANCH_OFFSET(a_off), .CALL(a_call), .RET(a_ret),
    .PC(a_pc), .STACK_EMPTY(a_empty), .STACK_FULL(a_full), .STACK_ERR(a_err)
  );

  pc_sequencer #(.PC_WIDTH(12), .OFFSET_WIDTH(8), .STACK_DEPTH(8)) dut_b (
    .CLOCK(CLOCK), .RESET(b_rst), .STALL(b_stall), .JUMP(b_jump), .JUMP_ADDR(b_jaddr),
    .BRANCH(b_branch), .BRANCH_OFFSET(b_off), .CALL(b_call), .RET(b_ret),
    .PC(b_pc), .STACK_EMPTY(b_empty), .STACK_FULL(b_full), .STACK_ERR(b_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit       stall, ret, call, jump, branch;
    bit [7:0] jaddr, off;
    bit [7:0] pc;
    bit       empty, full, err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit st, input bit rt, input bit cl, input bit jp, input bit br,
                     input bit [7:0] ja, input bit [7:0] of, input bit [7:0] epc,
                     input bit ee, input bit ef, input bit er);
    vec_t v;
    v.stall = st; v.ret = rt; v.call = cl; v.jump = jp; v.branch = br;
    v.jaddr = ja; v.off = of; v.pc = epc; v.empty = ee; v.full = ef; v.err = er;
    tbl.push_back(v);
  endtask

  // Drive A's inputs, let one falling edge pass, return 2 time units after it.
  task automatic apply_a(input bit st, input bit rt, input bit cl, input bit jp, input bit br,
                         input bit [7:0] ja, input bit [7:0] of);
    a_stall = st; a_ret = rt; a_call = cl; a_jump = jp; a_branch = br;
    a_jaddr = ja; a_off = of;
    @(negedge CLOCK);
    #2;
  endtask

  task automatic apply_b(input bit rt, input bit cl, input bit jp, input bit [11:0] ja);
    b_stall = 1'b0; b_ret = rt; b_call = cl; b_jump = jp; b_branch = 1'b0;
    b_jaddr = ja; b_off = '0;
    @(negedge CLOCK);
    #2;
  endtask

  // Asynchronous reset pulse between edges (caller sits 2 units after a falling edge).
  task automatic pulse_reset_a();
    #1 a_rst = 1'b1;
    #1;
    chk("async_reset_pc", int'(a_pc), 0);
    chk("async_reset_empty", int'(a_empty), 1);
    chk("async_reset_full", int'(a_full), 0);
    chk("async_reset_err", int'(a_err), 0);
    #1 a_rst = 1'b0;
  endtask

  // Behavioural reference model for instance A.
  int m_pc;
  int m_ras[$];
  bit m_err;

  task automatic model_step(input bit st, input bit rt, input bit cl, input bit jp, input bit br,
                            input int ja, input int of);
    int o;
    if (st) begin
      // nothing changes
    end else if (rt) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc = (m_pc + 1) % 256;
        m_err = 1'b1;
      end
    end else if (cl) begin
      if (m_ras.size() < 4) begin
        m_ras.push_back((m_pc + 1) % 256);
        m_pc = ja;
      end else begin
        m_pc = (m_pc + 1) % 256;
        m_err = 1'b1;
      end
    end else if (jp) begin
      m_pc = ja;
    end else if (br) begin
      o = (of >= 128) ? of - 256 : of;
      m_pc = (m_pc + o) & 255;
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st, rt, cl, jp, br;
    bit [7:0] ja, of;

    a_rst = 1'b1; a_stall = 0; a_ret = 0; a_call = 0; a_jump = 0; a_branch = 0;
    a_jaddr = '0; a_off = '0;
    b_rst = 1'b1; b_stall = 0; b_ret = 0; b_call = 0; b_jump = 0; b_branch = 0;
    b_jaddr = '0; b_off = '0;

    // Reset state.
    #12;
    chk("reset_pc", int'(a_pc), 0);
    chk("reset_empty", int'(a_empty), 1);
    chk("reset_full", int'(a_full), 0);
    chk("reset_err", int'(a_err), 0);
    a_rst = 1'b0;

    // Reset mid-count at PC=0x37.
    apply_a(0, 0, 0, 1, 0, 8'h37, 8'h00);
    chk("jump_to_37", int'(a_pc), 'h37);
    apply_a(0, 0, 0, 0, 0, 8'h00, 8'h00);
    chk("inc_to_38", int'(a_pc), 'h38);
    pulse_reset_a();

    // Directed table; starts from a freshly reset PC of 0.
    add(0,0,0,0,0, 8'h00, 8'h00, 8'h01, 1,0,0);
    add(0,0,0,0,0, 8'h00, 8'h00, 8'h02, 1,0,0);
    add(0,0,0,0,0, 8'h00, 8'h00, 8'h03, 1,0,0);
    add(0,0,0,1,0, 8'h10, 8'h00, 8'h10, 1,0,0);
    add(1,0,0,1,0, 8'h80, 8'h00, 8'h10, 1,0,0); // stall beats jump
    add(0,0,0,1,0, 8'h80, 8'h00, 8'h80, 1,0,0);
    add(0,0,0,1,0, 8'h20, 8'h00, 8'h20, 1,0,0);
    add(0,0,0,0,1, 8'h00, 8'hFC, 8'h1C, 1,0,0);
    add(0,0,0,1,0, 8'h02, 8'h00, 8'h02, 1,0,0);
    add(0,0,0,0,1, 8'h00, 8'hFC, 8'hFE, 1,0,0); // wraps below zero
    add(0,0,0,1,0, 8'hF0, 8'h00, 8'hF0, 1,0,0);
    add(0,0,0,0,1, 8'h00, 8'h20, 8'h10, 1,0,0); // wraps past top
    add(0,0,0,1,0, 8'hFF, 8'h00, 8'hFF, 1,0,0);
    add(0,0,0,0,0, 8'h00, 8'h00, 8'h00, 1,0,0); // increment from all-ones
    add(0,0,0,1,0, 8'h05, 8'h00, 8'h05, 1,0,0);
    add(0,0,1,0,0, 8'h40, 8'h00, 8'h40, 0,0,0); // nested calls
    add(0,0,1,0,0, 8'h60, 8'h00, 8'h60, 0,0,0);
    add(0,1,0,0,0, 8'h00, 8'h00, 8'h41, 0,0,0);
    add(0,1,0,0,0, 8'h00, 8'h00, 8'h06, 1,0,0);
    add(0,0,0,1,0, 8'h32, 8'h00, 8'h32, 1,0,0);
    add(0,0,1,0,0, 8'h70, 8'h00, 8'h70, 0,0,0); // pushes 0x33
    add(0,1,1,1,1, 8'h99, 8'h04, 8'h33, 1,0,0); // RET wins
    add(0,0,0,1,0, 8'h4C, 8'h00, 8'h4C, 1,0,0);
    add(0,0,1,0,0, 8'h4D, 8'h00, 8'h4D, 0,0,0);
    add(0,0,1,0,0, 8'h4E, 8'h00, 8'h4E, 0,0,0);
    add(0,0,1,0,0, 8'h4F, 8'h00, 8'h4F, 0,0,0);
    add(0,0,1,0,0, 8'h50, 8'h00, 8'h50, 0,1,0); // stack full
    add(0,0,1,0,0, 8'h90, 8'h00, 8'h51, 0,1,1); // overflow
    add(1,1,0,0,0, 8'h00, 8'h00, 8'h51, 0,1,1); // stall holds RAS too
    add(0,1,0,0,0, 8'h00, 8'h00, 8'h50, 0,0,1);
    add(0,1,0,0,0, 8'h00, 8'h00, 8'h4F, 0,0,1);
    add(0,1,0,0,0, 8'h00, 8'h00, 8'h4E, 0,0,1);
    add(0,1,0,0,0, 8'h00, 8'h00, 8'h4D, 1,0,1);

    foreach (tbl[i]) begin
      apply_a(tbl[i].stall, tbl[i].ret, tbl[i].call, tbl[i].jump, tbl[i].branch,
              tbl[i].jaddr, tbl[i].off);
      chk($sformatf("tbl%0d_pc", i), int'(a_pc), int'(tbl[i].pc));
      chk($sformatf("tbl%0d_empty", i), int'(a_empty), int'(tbl[i].empty));
      chk($sformatf("tbl%0d_full", i), int'(a_full), int'(tbl[i].full));
      chk($sformatf("tbl%0d_err", i), int'(a_err), int'(tbl[i].err));
    end

    // Underflow after reset, then error stays sticky until reset.
    pulse_reset_a();
    apply_a(0, 0, 0, 1, 0, 8'h09, 8'h00);
    apply_a(0, 1, 0, 0, 0, 8'h00, 8'h00);
    chk("underflow_pc", int'(a_pc), 'h0A);
    chk("underflow_err", int'(a_err), 1);
    chk("underflow_empty", int'(a_empty), 1);
    apply_a(0, 0, 1, 0, 0, 8'hC0, 8'h00);
    apply_a(0, 1, 0, 0, 0, 8'h00, 8'h00);
    chk("sticky_err_pc", int'(a_pc), 'h0B);
    chk("sticky_err", int'(a_err), 1);
    pulse_reset_a();

    // Randomized run against the model.
    m_pc = 0; m_ras.delete(); m_err = 1'b0;
    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(0, 7) == 0);
      rt = ($urandom_range(0, 4) == 0);
      cl = ($urandom_range(0, 3) == 0);
      jp = ($urandom_range(0, 5) == 0);
      br = ($urandom_range(0, 3) == 0);
      ja = 8'($urandom);
      of = 8'($urandom);
      apply_a(st, rt, cl, jp, br, ja, of);
      model_step(st, rt, cl, jp, br, int'(ja), int'(of));
      chk($sformatf("rnd%0d_pc", n), int'(a_pc), m_pc);
      chk($sformatf("rnd%0d_empty", n), int'(a_empty), int'(m_ras.size() == 0));
      chk($sformatf("rnd%0d_full", n), int'(a_full), int'(m_ras.size() == 4));
      chk($sformatf("rnd%0d_err", n), int'(a_err), int'(m_err));
      // Occasional reset keeps the error flag from saturating the run.
      if (n % 100 == 99) begin
        pulse_reset_a();
        m_pc = 0; m_ras.delete(); m_err = 1'b0;
      end
    end

    // Wider instance: nested call/return, fill to depth 8, overflow, wrap.
    b_rst = 1'b0;
    chk("b_reset_pc", int'(b_pc), 0);
    chk("b_reset_empty", int'(b_empty), 1);
    apply_b(0, 0, 1, 12'h805);
    apply_b(0, 1, 0, 12'hA40);
    chk("b_call1_pc", int'(b_pc), 'hA40);
    apply_b(0, 1, 0, 12'hF60);
    chk("b_call2_pc", int'(b_pc), 'hF60);
    apply_b(1, 0, 0, 12'h000);
    chk("b_ret1_pc", int'(b_pc), 'hA41);
    apply_b(1, 0, 0, 12'h000);
    chk("b_ret2_pc", int'(b_pc), 'h806);
    chk("b_ret2_empty", int'(b_empty), 1);
    chk("b_ret2_err", int'(b_err), 0);
    apply_b(0, 0, 1, 12'h100);
    for (int k = 0; k < 8; k++) begin
      apply_b(0, 1, 0, 12'(12'h101 + k));
    end
    chk("b_fill_pc", int'(b_pc), 'h108);
    chk("b_fill_full", int'(b_full), 1);
    chk("b_fill_err", int'(b_err), 0);
    apply_b(0, 1, 0, 12'hFFF);
    chk("b_ovf_pc", int'(b_pc), 'h109);
    chk("b_ovf_err", int'(b_err), 1);
    apply_b(1, 0, 0, 12'h000);
    chk("b_pop_pc", int'(b_pc), 'h108);
    chk("b_pop_full", int'(b_full), 0);
    apply_b(0, 0, 1, 12'hFFF);
    apply_b(0, 0, 0, 12'h000);
    chk("b_wrap_pc", int'(b_pc), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the nRisc instruction sequencer. Generates the instruction-memory address each cycle.
- Adds the following on top of the plain increment/user-load behaviour:
  - asynchronous reset to a vector
  - stall
  - absolute jump
  - signed relative branch
  - call/return via an internal return-address stack (RAS)
- Sits between control unit and instruction memory.

Parameters:
- PC_WIDTH, 8, width of PC and all address ports.
- OFFSET_WIDTH, 8, width of signed branch offset; must be <= PC_WIDTH.
- STACK_DEPTH, 4, number of RAS entries; must be >= 1.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- CLOCK  input  1  system clock; all state updates on the falling edge, matching the rest of the datapath.
- RESET  input  1  asynchronous, active-high reset.
- STALL  input  1  hold PC and RAS this cycle.
- JUMP  input  1  load JUMP_ADDR.
- JUMP_ADDR  input  PC_WIDTH  absolute target, used by JUMP and CALL.
- BRANCH  input  1  take relative branch.
- BRANCH_OFFSET  input  OFFSET_WIDTH  two's-complement offset.
- CALL  input  1  push PC+1, go to JUMP_ADDR.
- RET  input  1  pop RAS into PC.
- PC  output  PC_WIDTH  current instruction address (registered).
- STACK_EMPTY  output  1  RAS holds 0 entries.
- STACK_FULL  output  1  RAS holds STACK_DEPTH entries.
- STACK_ERR  output  1  sticky: overflow or underflow occurred.

Behaviour:
- Reset (async, any time, including mid-operation):
  - PC = RESET_VECTOR; RAS count = 0; STACK_EMPTY = 1; STACK_FULL = 0; STACK_ERR = 0.
  - RAS contents don't-care.
  - Reset overrides every other input.
- PC is a register; the update takes effect at the falling CLOCK edge. No combinational path from inputs to PC.
- Per-edge priority (highest first): STALL > RET > CALL > JUMP > BRANCH > increment.
  - STALL: PC, RAS and STACK_ERR unchanged.
  - RET, RAS non-empty: PC = top entry; count decrements.
  - RET, RAS empty (underflow): PC = PC+1; STACK_ERR set; count stays 0.
  - CALL, RAS not full: push (PC+1) mod 2^PC_WIDTH; PC = JUMP_ADDR; count increments.
  - CALL, RAS full (overflow): no push, no jump; PC = PC+1; STACK_ERR set.
  - JUMP: PC = JUMP_ADDR.
  - BRANCH: PC = PC + sign_extend(BRANCH_OFFSET), modulo 2^PC_WIDTH.
  - None asserted: PC = PC+1.
- Simultaneous lower-priority requests are ignored for that edge; they are not queued.
- Arithmetic:
  - All PC arithmetic wraps modulo 2^PC_WIDTH.
  - Increment from all-ones gives 0.
  - Negative branch below 0 wraps to the top of the address space.
- RAS:
  - LIFO, STACK_DEPTH entries, implemented with a count/pointer.
  - Entries pushed are read back only via RET.
  - Flag timing: STACK_FULL / STACK_EMPTY are decoded from the registered count and change on the same edge as the push/pop.
- STACK_ERR clears only on RESET.
- Latency:
  - Control request sampled at edge N is visible on PC immediately after edge N.
  - Back-to-back CALL/RET on consecutive edges are supported with no bubbles.

Test Plan:
- Reset/increment: assert RESET mid-count at PC=0x37 -> PC=0x00 immediately; STACK_EMPTY=1. After release, 3 edges -> PC=0x03. From PC=0xFF, one edge -> PC=0x00.
- Stall vs jump: PC=0x10, STALL=1 with JUMP=1, JUMP_ADDR=0x80 -> PC stays 0x10. Drop STALL -> next edge PC=0x80.
- Branch: PC=0x20, BRANCH_OFFSET=0xFC (-4) -> PC=0x1C. PC=0x02, offset 0xFC -> PC=0xFE. PC=0xF0, offset 0x20 -> PC=0x10.
- Nested call/return: at PC=0x05, CALL to 0x40; at 0x40, CALL to 0x60 -> RAS holds {0x06, 0x41}. RET -> 0x41; RET -> 0x06; STACK_EMPTY=1; STACK_ERR=0.
- Overflow/underflow: 4 CALLs fill RAS (STACK_FULL=1). A 5th CALL at PC=0x50 -> PC=0x51, STACK_ERR=1. After reset, RET with empty RAS at PC=0x09 -> PC=0x0A, STACK_ERR=1.
- Priority: RET, CALL, JUMP and BRANCH all high with RAS top=0x33 -> PC=0x33, count decrements. Sweep PC_WIDTH=12, STACK_DEPTH=8 and repeat the nested-call test.
